io_port_bank: RTL



---
 rtl/io_port_bank.sv | 199 +++++++++++++++++++
 1 files changed

// File: rtl/io_port_bank.sv
// io_port_bank: bus-mapped bank of bidirectional IO channels, each with a per-bit
// direction register, output latch, 2-flop input synchroniser and maskable change interrupt.

module io_port_bank_chk #(
    parameter int WIDTH = 8
) (
    input logic             clk,
    input logic             rst,
    input logic             RE,
    input logic             WE,
    input logic             io_read,
    input logic             io_write,
    input logic [WIDTH-1:0] Dout
);

    a_read_needs_re:   assert property (@(posedge clk) disable iff (rst) io_read |-> RE);
    a_write_needs_we:  assert property (@(posedge clk) disable iff (rst) io_write |-> WE);
    a_dout_idle_zero:  assert property (@(posedge clk) disable iff (rst)
                                        !$past(io_read) |-> (Dout == {WIDTH{1'b0}}));

endmodule

module io_port_bank #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 8,
    parameter int ADDR_W   = 8,
    parameter int BASE     = 0
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [ADDR_W-1:0]         addr,
    input  logic                      RE,
    input  logic                      WE,
    input  logic [WIDTH-1:0]          Din,
    output logic [WIDTH-1:0]          Dout,
    output logic                      io_read,
    output logic                      io_write,
    output logic                      irq,
    inout  wire  [CHANNELS*WIDTH-1:0] IO
);

    localparam int                NBITS    = CHANNELS * WIDTH;
    localparam int                NREGS    = 2 * CHANNELS + 2;
    localparam logic [ADDR_W:0]   BASE_X   = (ADDR_W+1)'(BASE);
    localparam logic [ADDR_W:0]   WIN_X    = (ADDR_W+1)'(NREGS);
    localparam logic [ADDR_W-1:0] OFF_FLAG = ADDR_W'(2 * CHANNELS);
    localparam logic [ADDR_W-1:0] OFF_MASK = ADDR_W'(2 * CHANNELS + 1);

    logic [NBITS-1:0]    r_out;
    logic [NBITS-1:0]    r_dir;
    logic [NBITS-1:0]    r_s1;
    logic [NBITS-1:0]    r_sync;
    logic [NBITS-1:0]    r_prev;
    logic [CHANNELS-1:0] r_flag;
    logic [CHANNELS-1:0] r_mask;
    logic [1:0]          r_prime;

    logic [ADDR_W:0]     w_diff;
    logic                w_hit;
    logic [ADDR_W-1:0]   w_off;
    logic [CHANNELS-1:0] w_sel_data;
    logic [CHANNELS-1:0] w_sel_dir;
    logic                w_sel_flag;
    logic                w_sel_mask;
    logic [WIDTH-1:0]    w_flag_ext;
    logic [WIDTH-1:0]    w_mask_ext;
    logic [WIDTH-1:0]    w_rdata;
    logic [CHANNELS-1:0] w_chg;
    logic [CHANNELS-1:0] w_clr;
    logic [CHANNELS-1:0] w_flag_nxt;
    logic                w_primed;

    // The extra top bit of the difference is a borrow: set means addr is below BASE.
    assign w_diff   = {1'b0, addr} - BASE_X;
    assign w_hit    = ~w_diff[ADDR_W] && (w_diff < WIN_X);
    assign w_off    = w_diff[ADDR_W-1:0];
    assign io_read  = RE & w_hit;
    assign io_write = WE & w_hit;

    // Register-window decode into one-hot selects
    always_comb begin
        w_sel_data = {CHANNELS{1'b0}};
        w_sel_dir  = {CHANNELS{1'b0}};
        for (int i = 0; i < CHANNELS; i++) begin
            w_sel_data[i] = w_hit && (w_off == ADDR_W'(i));
            w_sel_dir[i]  = w_hit && (w_off == ADDR_W'(CHANNELS + i));
        end
        w_sel_flag = w_hit && (w_off == OFF_FLAG);
        w_sel_mask = w_hit && (w_off == OFF_MASK);
    end

    // Zero-extend the per-channel registers to bus width
    always_comb begin
        w_flag_ext                 = {WIDTH{1'b0}};
        w_mask_ext                 = {WIDTH{1'b0}};
        w_flag_ext[CHANNELS-1:0]   = r_flag;
        w_mask_ext[CHANNELS-1:0]   = r_mask;
    end

    // Read mux as an AND-OR tree over the one-hot selects
    always_comb begin
        w_rdata = ({WIDTH{w_sel_flag}} & w_flag_ext) | ({WIDTH{w_sel_mask}} & w_mask_ext);
        for (int i = 0; i < CHANNELS; i++) begin
            w_rdata = w_rdata
                    | ({WIDTH{w_sel_data[i]}} & r_sync[i*WIDTH +: WIDTH])
                    | ({WIDTH{w_sel_dir[i]}}  & r_dir[i*WIDTH +: WIDTH]);
        end
    end

    // Per-channel change detect between successive synchronised samples
    always_comb begin
        w_chg = {CHANNELS{1'b0}};
        for (int i = 0; i < CHANNELS; i++) begin
            w_chg[i] = |(r_sync[i*WIDTH +: WIDTH] ^ r_prev[i*WIDTH +: WIDTH]);
        end
    end

    // Setting is OR-ed in after the clear so a coincident change wins.
    assign w_primed   = (r_prime == 2'd3);
    assign w_clr      = {CHANNELS{WE & w_sel_flag}} & Din[CHANNELS-1:0];
    assign w_flag_nxt = (r_flag & ~w_clr) | ({CHANNELS{w_primed}} & w_chg);

    // Output latches and direction registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out <= {NBITS{1'b0}};
            r_dir <= {NBITS{1'b0}};
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                if (WE && w_sel_data[i]) begin
                    r_out[i*WIDTH +: WIDTH] <= Din;
                end
                if (WE && w_sel_dir[i]) begin
                    r_dir[i*WIDTH +: WIDTH] <= Din;
                end
            end
        end
    end

    // Input synchroniser, previous-sample register and post-reset priming counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1    <= {NBITS{1'b0}};
            r_sync  <= {NBITS{1'b0}};
            r_prev  <= {NBITS{1'b0}};
            r_prime <= 2'd0;
        end else begin
            r_s1   <= IO;
            r_sync <= r_s1;
            r_prev <= r_sync;
            if (!w_primed) begin
                r_prime <= r_prime + 2'd1;
            end
        end
    end

    // Change flags, interrupt mask and registered interrupt request
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_flag <= {CHANNELS{1'b0}};
            r_mask <= {CHANNELS{1'b0}};
            irq    <= 1'b0;
        end else begin
            r_flag <= w_flag_nxt;
            if (WE && w_sel_mask) begin
                r_mask <= Din[CHANNELS-1:0];
            end
            irq <= |(r_flag & r_mask);
        end
    end

    // Registered read data; zero on every edge without a read hit
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            Dout <= {WIDTH{1'b0}};
        end else if (io_read) begin
            Dout <= w_rdata;
        end else begin
            Dout <= {WIDTH{1'b0}};
        end
    end

    for (genvar b = 0; b < NBITS; b++) begin : g_pin
        assign IO[b] = r_dir[b] ? r_out[b] : 1'bz;
    end

    io_port_bank_chk #(
        .WIDTH (WIDTH)
    ) u_chk (
        .clk      (clk),
        .rst      (rst),
        .RE       (RE),
        .WE       (WE),
        .io_read  (io_read),
        .io_write (io_write),
        .Dout     (Dout)
    );

endmodule
